contador_mes: RTL
=================

// Module: contador_mes
// PURPOSE
//   Month-of-year counter for the RTC datapath, directly upstream of the month decoder.
//   Holds month index 0..11 (0=Jan) and drives the decoder's 4-bit Ref input.
//   Advances on the day-counter rollover. Supports user edit with Up/Down auto-repeat and a parallel load.
//   Emits a year-carry pulse, plus days-in-month for the day counter.
// PARAMETERS
//   REP_DELAY  25_000_000  cycles Up/Down must be held after first step before auto-repeat begins
//   REP_RATE   5_000_000   cycles between auto-repeat steps while held (REP_RATE >= 1, REP_DELAY >= 1)
// PORTS
//   Clock      in   1  system clock, all logic on rising edge
//   Reset      in   1  synchronous, active-low reset
//   Tick_dia   in   1  1-cycle pulse: day counter wrapped past last day of month
//   Edit       in   1  level: 1 = user edit mode for month field
//   Up         in   1  level, already synchronized/debounced: increment request
//   Down       in   1  level, already synchronized/debounced: decrement request
//   Load       in   1  1-cycle pulse: load Load_val into month
//   Load_val   in   4  month index to load, valid range 0..11
//   Bisiesto   in   1  level: current year is a leap year
//   Ref        out  4  registered month index 0..11, to month decoder
//   Carry_anio out  1  registered 1-cycle pulse: Dec->Jan via Tick_dia
//   Dias_max   out  5  days in current month (28/29/30/31), combinational from Ref and Bisiesto
//   Editando   out  1  registered copy of FSM state (1 in EDIT)
//   Load_err   out  1  registered 1-cycle pulse: Load with Load_val > 11
// BEHAVIOUR
//   Reset (Reset==0 at clock edge): Ref=0, Carry_anio=0, Editando=0, Load_err=0, FSM=RUN.
//   Reset also clears the repeat counter and the Up/Down previous-state flops. Applies mid-edit/mid-repeat.
//   FSM states:
//     RUN: default.
//     EDIT: entered on the cycle after Edit samples 1; returns to RUN on the cycle after Edit samples 0.
//   Per-cycle priority: Load > EDIT stepping > Tick_dia.
//   Load:
//     Load_val<=11: Ref<=Load_val next cycle, in any state; suppresses all other actions that cycle.
//     Load_val>11: Ref unchanged, Load_err=1 for one cycle; other actions that cycle proceed normally.
//   RUN:
//     Tick_dia=1 and Ref<11: Ref<=Ref+1.
//     Tick_dia=1 and Ref==11: Ref<=0 and Carry_anio=1 on the same edge.
//     Up/Down ignored.
//   EDIT:
//     Tick_dia ignored; Carry_anio never asserted.
//     Step up: Ref<=(Ref==11)?0:Ref+1. Step down: Ref<=(Ref==0)?11:Ref-1. No carry on wrap.
//     Exactly one of Up/Down high, rising edge versus previous sample: one step.
//       The same edge loads repeat counter := REP_DELAY.
//     Still held: counter decrements each cycle; at 0 one step, reload REP_RATE.
//     Up and Down both high, or both low: no step, counter cleared.
//     Switching direction while held: counts as a new rising edge.
//   Dias_max:
//     31 for Ref in {0,2,4,6,7,9,11}; 30 for {3,5,8,10}.
//     Ref==1: 29 if Bisiesto else 28.
//   Ref never leaves 0..11 under any input sequence.
//   Carry_anio/Load_err are never high two consecutive cycles from one event.
// TESTING
//   Reset low 1 cycle -> Ref=0, Dias_max=31, Carry_anio=0, Editando=0.
//   RUN, 12 Tick_dia pulses from Ref=0 -> Ref 1..11, then 0.
//     Carry_anio=1 only on the 11->0 edge.
//   Load 4'd1 with Bisiesto=0 -> Ref=1, Dias_max=28; Bisiesto=1 -> 29.
//     Then Load 4'd13 -> Ref stays 1, Load_err 1 cycle.
//   EDIT with REP_DELAY=4, REP_RATE=2:
//     Hold Up 10 cycles from Ref=10 -> steps at cycles 0, 4, 6, 8; Ref 11, 0, 1, 2.
//     No Carry_anio. Tick_dia during the hold is ignored.
//   EDIT, Down from Ref=0 -> 11.
//     Up+Down together -> no change.
//     Load 4'd6 concurrent with Up edge -> Ref=6 only.
//   Reset asserted mid auto-repeat in EDIT -> Ref=0, Editando=0.
//     Held Up after release of Reset with Edit=1 causes no step until a new rising edge.

Source files
------------

// File: rtl/contador_mes_if.sv
// ============================================================================
// contador_mes_if : month counter control and status bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface contador_mes_if;
  logic       i_tick_dia;
  logic       i_edit;
  logic       i_up;
  logic       i_down;
  logic       i_load;
  logic [3:0] i_load_val;
  logic       i_bisiesto;
  logic [3:0] o_ref;
  logic       o_carry_anio;
  logic [4:0] o_dias_max;
  logic       o_editando;
  logic       o_load_err;

  modport master (
    output i_tick_dia, i_edit, i_up, i_down, i_load, i_load_val, i_bisiesto,
    input  o_ref, o_carry_anio, o_dias_max, o_editando, o_load_err
  );

  modport slave (
    input  i_tick_dia, i_edit, i_up, i_down, i_load, i_load_val, i_bisiesto,
    output o_ref, o_carry_anio, o_dias_max, o_editando, o_load_err
  );
endinterface

`default_nettype wire

// File: rtl/contador_mes.sv
// ============================================================================
// contador_mes : month-of-year counter (0..11) with edit auto-repeat and load
// Revision 1.0
// ============================================================================
`default_nettype none

module contador_mes #(
  parameter int REP_DELAY = 25_000_000,
  parameter int REP_RATE  = 5_000_000
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  contador_mes_if.slave    bus
);

  localparam int c_rep_max = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int c_cnt_w   = $clog2(c_rep_max + 1);
  localparam logic [c_cnt_w-1:0] c_delay = c_cnt_w'(REP_DELAY);
  localparam logic [c_cnt_w-1:0] c_rate  = c_cnt_w'(REP_RATE);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
  localparam logic [3:0]         c_last  = 4'd11;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  state_t             r_state;
  logic [3:0]         r_ref;
  logic               r_carry;
  logic               r_load_err;
  logic               r_editando;
  logic               r_prev_up;
  logic               r_prev_dn;
  logic [c_cnt_w-1:0] r_rep_cnt;

  logic       w_load_ok;
  logic       w_one;
  logic       w_rise;
  logic [3:0] w_ref_inc;
  logic [3:0] w_ref_dec;
  logic [3:0] w_ref_step;

  assign w_load_ok  = bus.i_load && (bus.i_load_val <= c_last);
  assign w_one      = bus.i_up ^ bus.i_down;
  // A direction switch while held also counts as a rising edge.
  assign w_rise     = w_one && (bus.i_up ? !r_prev_up : !r_prev_dn);
  assign w_ref_inc  = (r_ref == c_last) ? 4'd0 : r_ref + 4'd1;
  assign w_ref_dec  = (r_ref == 4'd0) ? c_last : r_ref - 4'd1;
  assign w_ref_step = bus.i_up ? w_ref_inc : w_ref_dec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_editando <= 1'b0;
      r_ref      <= 4'd0;
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
      r_prev_up  <= 1'b0;
      r_prev_dn  <= 1'b0;
      r_rep_cnt  <= '0;
    end else begin
      r_prev_up  <= bus.i_up;
      r_prev_dn  <= bus.i_down;
      r_state    <= bus.i_edit ? ST_EDIT : ST_RUN;
      r_editando <= bus.i_edit;
      r_carry    <= 1'b0;
      r_load_err <= bus.i_load && !w_load_ok;

      if (w_load_ok) begin
        r_ref     <= bus.i_load_val;
        r_rep_cnt <= '0;
      end else if (r_state == ST_EDIT) begin
        // A zero counter while held means "not armed": no step until a new edge.
        if (!w_one) begin
          r_rep_cnt <= '0;
        end else if (w_rise) begin
          r_ref     <= w_ref_step;
          r_rep_cnt <= c_delay;
        end else if (r_rep_cnt == c_one) begin
          r_ref     <= w_ref_step;
          r_rep_cnt <= c_rate;
        end else if (r_rep_cnt != '0) begin
          r_rep_cnt <= r_rep_cnt - c_one;
        end
      end else begin
        r_rep_cnt <= '0;
        if (bus.i_tick_dia) begin
          r_ref   <= w_ref_inc;
          r_carry <= (r_ref == c_last);
        end
      end
    end
  end

  always_comb begin
    bus.o_dias_max = 5'd31;
    case (r_ref)
      4'd1:                      bus.o_dias_max = bus.i_bisiesto ? 5'd29 : 5'd28;
      4'd3, 4'd5, 4'd8, 4'd10:   bus.o_dias_max = 5'd30;
      default:                   bus.o_dias_max = 5'd31;
    endcase
  end

  assign bus.o_ref        = r_ref;
  assign bus.o_carry_anio = r_carry;
  assign bus.o_editando   = r_editando;
  assign bus.o_load_err   = r_load_err;

endmodule

`default_nettype wire
